// File: rtl/midi_note_ctrl.sv
// midi_note_ctrl: MIDI byte-stream parser feeding a last-note-priority held-note stack.
// Drives a single voice with the most recently pressed key that is still held.
module midi_note_ctrl #(
  parameter int DEPTH   = 8,
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] note,
  output logic       key_on,
  output logic [6:0] velocity,
  output logic       retrig,
  output logic [4:0] depth_cnt
);

  localparam logic [4:0] DEPTH_W = 5'(DEPTH);
  localparam logic [3:0] CHAN_W  = 4'(CHANNEL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;

  logic       msg_done;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;

  logic       ch_match;
  logic       ev_on;
  logic       ev_off;
  logic       ev_all;
  logic [6:0] ev_note;
  logic [6:0] ev_vel;

  logic [6:0] stk_note_q [DEPTH];
  logic [6:0] stk_note_d [DEPTH];
  logic [6:0] stk_vel_q  [DEPTH];
  logic [6:0] stk_vel_d  [DEPTH];
  logic [4:0] depth_q, depth_d;

  logic       hit;
  logic [4:0] hit_idx;

  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       retrig_q, retrig_d;

  // Parser: classify each byte, track running status and collect data bytes into messages.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    msg_done = 1'b0;
    msg_d1   = 7'd0;
    msg_d2   = 7'd0;
    if (byte_valid) begin
      if (byte_in >= 8'hF8) begin
        state_d = state_q;
      end else if (byte_in >= 8'hF0) begin
        state_d  = ST_IDLE;
        status_d = 8'h00;
      end else if (byte_in[7]) begin
        state_d  = ST_WAIT_D1;
        status_d = byte_in;
      end else begin
        case (state_q)
          ST_WAIT_D1: begin
            if (status_q[7:4] == 4'hC || status_q[7:4] == 4'hD) begin
              msg_done = 1'b1;
              msg_d1   = byte_in[6:0];
            end else begin
              d1_d    = byte_in[6:0];
              state_d = ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            msg_done = 1'b1;
            msg_d1   = d1_q;
            msg_d2   = byte_in[6:0];
            state_d  = ST_WAIT_D1;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  // Event decode: turn a completed message on our channel into note-on/note-off/all-off.
  always_comb begin
    ch_match = OMNI || (status_q[3:0] == CHAN_W);
    ev_on    = 1'b0;
    ev_off   = 1'b0;
    ev_all   = 1'b0;
    ev_note  = msg_d1;
    ev_vel   = msg_d2;
    if (msg_done && ch_match) begin
      case (status_q[7:4])
        4'h9: begin
          if (msg_d2 != 7'd0) ev_on = 1'b1;
          else                ev_off = 1'b1;
        end
        4'h8: ev_off = 1'b1;
        4'hB: begin
          if (msg_d1 == 7'd123 || msg_d1 == 7'd120) ev_all = 1'b1;
        end
        default: ev_all = 1'b0;
      endcase
    end
  end

  // Find the event's note among the valid stack entries (at most one match can exist).
  always_comb begin
    hit     = 1'b0;
    hit_idx = 5'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && (5'(i) < depth_q) && (stk_note_q[i] == ev_note)) begin
        hit     = 1'b1;
        hit_idx = 5'(i);
      end
    end
  end

  // Stack update: push on top (dropping a duplicate or the oldest entry), remove on release.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stk_note_d[i] = stk_note_q[i];
      stk_vel_d[i]  = stk_vel_q[i];
    end
    depth_d  = depth_q;
    retrig_d = 1'b0;
    if (ev_all) begin
      depth_d = 5'd0;
    end else if (ev_on) begin
      stk_note_d[0] = ev_note;
      stk_vel_d[0]  = ev_vel;
      for (int i = 1; i < DEPTH; i++) begin
        if (!hit || (5'(i) <= hit_idx)) begin
          stk_note_d[i] = stk_note_q[i-1];
          stk_vel_d[i]  = stk_vel_q[i-1];
        end
      end
      if (!hit && (depth_q != DEPTH_W)) depth_d = depth_q + 5'd1;
      retrig_d = 1'b1;
    end else if (ev_off && hit) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (5'(i) >= hit_idx) begin
          stk_note_d[i] = stk_note_q[i+1];
          stk_vel_d[i]  = stk_vel_q[i+1];
        end
      end
      depth_d = depth_q - 5'd1;
    end
  end

  // Output values follow the top entry while notes are held and otherwise keep their pitch.
  always_comb begin
    note_d = note_q;
    vel_d  = vel_q;
    if (depth_d != 5'd0) begin
      note_d = stk_note_d[0];
      vel_d  = stk_vel_d[0];
    end
  end

  // State register for parser, stack and outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      status_q <= 8'h00;
      d1_q     <= 7'd0;
      depth_q  <= 5'd0;
      note_q   <= 7'd0;
      vel_q    <= 7'd0;
      retrig_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_note_q[i] <= 7'd0;
        stk_vel_q[i]  <= 7'd0;
      end
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
      depth_q  <= depth_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      retrig_q <= retrig_d;
      for (int i = 0; i < DEPTH; i++) begin
        stk_note_q[i] <= stk_note_d[i];
        stk_vel_q[i]  <= stk_vel_d[i];
      end
    end
  end

  assign note      = {1'b0, note_q};
  assign velocity  = vel_q;
  assign key_on    = (depth_q != 5'd0);
  assign retrig    = retrig_q;
  assign depth_cnt = depth_q;

endmodule

// File: tb/tb_midi_note_ctrl.sv
// tb_midi_note_ctrl: directed plus randomized MIDI streams checked against a queue-based model.
module tb_midi_note_ctrl;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic [7:0] note;
   logic       key_on;
   logic [6:0] velocity;
   logic       retrig;
   logic [4:0] depth_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: running status, collected data bytes, held notes (index 0 = newest).
   int rs;
   int data[$];
   int mNotes[$];
   int mVels[$];
   int expNote;
   int expVel;
   int expRetrig;

   midi_note_ctrl #(.DEPTH(DEPTH), .CHANNEL(0), .OMNI(1'b0)) dut (
      .Clk(clk),
      .Reset(rst),
      .byte_in(byte_in),
      .byte_valid(byte_valid),
      .note(note),
      .key_on(key_on),
      .velocity(velocity),
      .retrig(retrig),
      .depth_cnt(depth_cnt)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic modelReset();
      rs = -1;
      data.delete();
      mNotes.delete();
      mVels.delete();
      expNote = 0;
      expVel = 0;
      expRetrig = 0;
   endtask

   task automatic removeNote(input int n);
      for (int i = 0; i < mNotes.size(); i++) begin
         if (mNotes[i] == n) begin
            mNotes.delete(i);
            mVels.delete(i);
            return;
         end
      end
   endtask

   task automatic modelMessage(input int st, input int d1, input int d2);
      int hi;
      hi = st >> 4;
      if ((st & 15) != 0) return;
      if (hi == 9 && d2 > 0) begin
         removeNote(d1);
         mNotes.push_front(d1);
         mVels.push_front(d2);
         if (mNotes.size() > DEPTH) begin
            void'(mNotes.pop_back());
            void'(mVels.pop_back());
         end
         expRetrig = 1;
      end else if (hi == 9 || hi == 8) begin
         removeNote(d1);
      end else if (hi == 11 && (d1 == 123 || d1 == 120)) begin
         mNotes.delete();
         mVels.delete();
      end
   endtask

   task automatic modelByte(input int b);
      int need;
      expRetrig = 0;
      if (b >= 8'hF8) begin
         return;
      end else if (b >= 8'hF0) begin
         rs = -1;
         data.delete();
      end else if (b >= 8'h80) begin
         rs = b;
         data.delete();
      end else if (rs >= 0) begin
         data.push_back(b);
         need = ((rs >> 4) == 12 || (rs >> 4) == 13) ? 1 : 2;
         if (data.size() == need) begin
            modelMessage(rs, data[0], (need == 2) ? data[1] : 0);
            data.delete();
         end
      end
      if (mNotes.size() > 0) begin
         expNote = mNotes[0];
         expVel = mVels[0];
      end
   endtask

   task automatic checkOutput(input string tag);
      checks++;
      assert (note === 8'(expNote)) else begin
         errors++;
         $error("[TB] FAIL %s note observed %0h expected %0h", tag, note, expNote);
      end
      checks++;
      assert (velocity === 7'(expVel)) else begin
         errors++;
         $error("[TB] FAIL %s velocity observed %0h expected %0h", tag, velocity, expVel);
      end
      checks++;
      assert (key_on === (mNotes.size() != 0)) else begin
         errors++;
         $error("[TB] FAIL %s key_on observed %0b expected %0b", tag, key_on, mNotes.size() != 0);
      end
      checks++;
      assert (depth_cnt === 5'(mNotes.size())) else begin
         errors++;
         $error("[TB] FAIL %s depth_cnt observed %0d expected %0d", tag, depth_cnt, mNotes.size());
      end
      checks++;
      assert (retrig === expRetrig[0]) else begin
         errors++;
         $error("[TB] FAIL %s retrig observed %0b expected %0b", tag, retrig, expRetrig[0]);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input string tag);
      @(negedge clk);
      byte_in = b;
      byte_valid = 1'b1;
      modelByte(int'(b));
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      checkOutput(tag);
   endtask

   task automatic idleCycle(input string tag);
      @(negedge clk);
      byte_valid = 1'b0;
      expRetrig = 0;
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   task automatic sendList(input logic [7:0] seq[$], input string tag);
      foreach (seq[i]) applyStimulus(seq[i], tag);
   endtask

   initial begin
      int r;
      logic [7:0] st;
      rst = 1'b1;
      byte_in = 8'h00;
      byte_valid = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      @(negedge clk);
      rst = 1'b0;

      sendList('{8'h90, 8'h3C, 8'h64}, "noteon_basic");
      sendList('{8'h80, 8'h3C, 8'h00}, "noteoff_hold");
      idleCycle("idle_hold");

      sendList('{8'h90, 8'h3C, 8'h40, 8'h40, 8'h50, 8'h3C, 8'h00, 8'h40, 8'h00}, "running_status");

      sendList('{8'h90, 8'h30, 8'h10, 8'h34, 8'h20, 8'h37, 8'h30}, "legato_press");
      sendList('{8'h37, 8'h00, 8'h30, 8'h00}, "legato_release");
      sendList('{8'h34, 8'h00}, "legato_empty");

      for (int n = 8'h20; n <= 8'h28; n++) sendList('{8'(n), 8'h45}, "overflow_on");
      for (int n = 8'h28; n >= 8'h21; n--) sendList('{8'(n), 8'h00}, "overflow_off");

      sendList('{8'h91, 8'h3C, 8'h64}, "other_channel");
      sendList('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64}, "realtime_transparent");
      sendList('{8'h90, 8'h3C, 8'hF0, 8'h64}, "sysex_clears");
      sendList('{8'h90, 8'h3C, 8'h40, 8'h20}, "repress_held");

      sendList('{8'h90, 8'h50, 8'h11, 8'h52, 8'h22, 8'h54, 8'h33}, "allof_setup");
      sendList('{8'hB0, 8'h7B, 8'h00}, "all_notes_off");

      applyStimulus(8'h90, "reset_mid_msg");
      @(negedge clk);
      rst = 1'b1;
      modelReset();
      #2;
      checkOutput("async_reset");
      @(negedge clk);
      rst = 1'b0;
      sendList('{8'h3C, 8'h64, 8'h70}, "after_reset");

      for (int m = 0; m < 150; m++) begin
         r = $urandom_range(0, 10);
         case (r)
            0, 1, 2, 3: st = 8'h90;
            4:          st = 8'h80;
            5:          st = 8'h91;
            6:          st = 8'hB0;
            7:          st = 8'hC0;
            8:          st = 8'hF0;
            default:    st = 8'h00;
         endcase
         if (st != 8'h00) applyStimulus(st, "rand_status");
         if ($urandom_range(0, 7) == 0) applyStimulus(8'hF8, "rand_realtime");
         if (st == 8'hB0 && $urandom_range(0, 1) == 0)
            applyStimulus(($urandom_range(0, 1) == 0) ? 8'd123 : 8'd120, "rand_d1");
         else
            applyStimulus(8'(8'h30 + $urandom_range(0, 11)), "rand_d1");
         if ($urandom_range(0, 7) == 0) applyStimulus(8'hFA, "rand_realtime");
         if ($urandom_range(0, 3) == 0) applyStimulus(8'h00, "rand_d2");
         else applyStimulus(8'($urandom_range(1, 127)), "rand_d2");
         if ($urandom_range(0, 9) == 0) idleCycle("rand_idle");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/midi_note_ctrl.md
Name: midi_note_ctrl

Overview:
- Sits between the MIDI UART receiver and a voice. Parses the received MIDI byte stream and drives the voice's note number and key_on inputs.
- Parses note-on, note-off, running status and all-notes-off for one MIDI channel.
- Keeps a held-note stack so the voice always plays the most recently pressed key that is still held (last-note priority, legato).
- Note output holds its value after release so the voice's release and glide phases keep their pitch.

Parameters:
- DEPTH, 8, held-note stack entries (2..16).
- CHANNEL, 0, MIDI channel 0..15 this block responds to.
- OMNI, 0, 1 = respond to all channels.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- byte_in  in  8  received MIDI byte
- byte_valid  in  1  byte_in valid for this cycle; may be high every cycle
- note  out  8  current note number, bit 7 always 0; drives the voice F_in
- key_on  out  1  high while at least one note is held
- velocity  out  7  velocity of the note currently on top of the stack
- retrig  out  1  one-cycle pulse when a new note-on reaches the top of the stack
- depth_cnt  out  5  number of notes currently held (debug)

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, stack empty, parser state IDLE, running status cleared. Reset asserted mid-message discards that message.
- Byte classes:
  - 0xF8-0xFF (realtime): ignored entirely; parser state and running status unchanged, even between data bytes.
  - 0xF0-0xF7: clear running status; parser goes to IDLE.
  - 0x80-0xEF (channel status): latch status and channel as running status; parser goes to WAIT_D1.
  - 0x00-0x7F (data): advance the parser; ignored in IDLE.
- Parser FSM:
  - IDLE -(status 0x80-0xEF)-> WAIT_D1.
  - WAIT_D1 -(data)-> for 0xCn/0xDn, message complete, back to WAIT_D1 (running status); otherwise latch d1 and go to WAIT_D2.
  - WAIT_D2 -(data)-> message complete, back to WAIT_D1.
  - A status byte in any state restarts the parser at WAIT_D1 with the new status; any partial message is dropped.
- A completed message acts only if its channel equals CHANNEL or OMNI=1. Acting messages:
  - 0x9n with vel>0: NOTE_ON(d1, vel).
  - 0x9n with vel=0, or 0x8n with any velocity: NOTE_OFF(d1).
  - 0xBn with d1=123 or d1=120: ALL_OFF.
  - All other messages are consumed and ignored.
- Event timing: the stack update and all outputs are registered in the cycle after the completing byte (latency 1 cycle). byte_valid every cycle is sustained with no stall.
- Stack: entry 0 is the top; each entry holds {note, velocity}.
  - NOTE_ON when the note is already held: remove the old entry, push the new one on top with the new velocity. depth unchanged.
  - NOTE_ON when the stack is full: the bottom (oldest) entry is discarded, then push. depth stays DEPTH.
  - NOTE_OFF of a held note: remove it and compact the entries below upward by one.
  - NOTE_OFF of a note not held: no effect.
  - ALL_OFF: empty the stack.
- Outputs:
  - key_on = (depth != 0).
  - When depth > 0: note and velocity equal the top entry.
  - When depth = 0: note and velocity hold their last values; they do not reset.
  - retrig pulses for exactly 1 cycle on every NOTE_ON, including a re-press of a held note.
  - retrig does not pulse when a NOTE_OFF exposes an older note (legato: pitch changes, key_on stays 1).
- Only one event is applied per cycle; no simultaneous events are possible because one byte is accepted per cycle.

Test Plan:
- 90 3C 64 -> one cycle after 0x64: note=0x3C, velocity=0x64, key_on=1, retrig=1 for 1 cycle; then 80 3C 00 -> key_on=0, note stays 0x3C.
- 90 3C 40, then running status 40 50 then 3C 00 -> note goes 0x3C, then 0x40, then after 3C 00 stays 0x40 with depth=1; 40 00 -> key_on=0.
- Legato: 90 30 10, 34 20, 37 30; release 37 -> note=0x34, velocity=0x20, key_on=1, no retrig; release 30 -> note stays 0x34, depth=1.
- Overflow with DEPTH=8: note-on for 0x20..0x28 (9 notes) -> depth=8, 0x20 discarded; releasing 0x28..0x21 in order leaves key_on=0 with no stale 0x20.
- Filtering with CHANNEL=0, OMNI=0: 91 3C 64 -> no change. 90 F8 3C FE 64 -> note-on 0x3C (realtime bytes transparent). 90 3C F0 64 -> no event (running status cleared).
- B0 7B 00 with 3 notes held -> key_on=0, depth=0. Reset asserted between 90 and 3C, then 64 70 -> no event; all outputs 0.
